// File: rtl/loop_unroll_ctrl_pkg.sv
// Shared definitions for the loop unroll sequencer.
//   state_t : sequencer state encoding (IDLE, REPLAY, FINISH)
//   PC_W    : program counter width
//   ITER_W  : replay iteration counter width
package loop_unroll_ctrl_pkg;

  localparam int unsigned PC_W   = 16;
  localparam int unsigned ITER_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REPLAY = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/loop_unroll_ctrl.sv
// Loop unroll sequencer between fetch and the instruction interpreter.
// On a predicted-taken backward branch with a short enough body, captures the
// body bounds and replays the body PCs to fetch UNROLL_CNT-1 times, then
// pulses the finish/redirect strobes that squash decode and send fetch past
// the loop end.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   inst_valid_in, bck_lp_in,
//   pred_result_in                   trigger qualifiers from decode/interpreter
//   brn_pc_in, brn_tgt_in            loop end / loop start PCs
//   stall_in                         freezes replay
//   mispred_in                       flush, aborts unrolling
//   fetch_pc_out, fetch_v_out        replayed PC to fetch
//   unrll_active_out, iter_out       replay status
//   fnsh_unrll_out                   finish pulse to interpreter
//   redirect_v_out, redirect_pc_out  fetch redirect to loop end + 1
// All outputs are registered.
module loop_unroll_ctrl
  import loop_unroll_ctrl_pkg::*;
#(
  parameter int unsigned UNROLL_CNT = 4,
  parameter int unsigned MAX_BODY   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid_in,
  input  logic              bck_lp_in,
  input  logic              pred_result_in,
  input  logic [PC_W-1:0]   brn_pc_in,
  input  logic [PC_W-1:0]   brn_tgt_in,
  input  logic              stall_in,
  input  logic              mispred_in,
  output logic [PC_W-1:0]   fetch_pc_out,
  output logic              fetch_v_out,
  output logic              unrll_active_out,
  output logic [ITER_W-1:0] iter_out,
  output logic              fnsh_unrll_out,
  output logic              redirect_v_out,
  output logic [PC_W-1:0]   redirect_pc_out
);

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(UNROLL_CNT - 1);

  // Sequencer state
  state_t            r_state,  w_state_nxt;
  logic [PC_W-1:0]   r_start,  w_start_nxt;
  logic [PC_W-1:0]   r_end,    w_end_nxt;
  logic [PC_W-1:0]   r_pc,     w_pc_nxt;
  logic [ITER_W-1:0] r_iter,   w_iter_nxt;

  // Output registers
  logic [PC_W-1:0]   r_fetch_pc,  w_fetch_pc_nxt;
  logic              r_fetch_v,   w_fetch_v_nxt;
  logic              r_active,    w_active_nxt;
  logic [ITER_W-1:0] r_iter_out,  w_iter_out_nxt;
  logic              r_fnsh,      w_fnsh_nxt;
  logic              r_redir_v,   w_redir_v_nxt;
  logic [PC_W-1:0]   r_redir_pc,  w_redir_pc_nxt;

  // Body length in 17 bits so a reversed range cannot alias to a small length
  logic [PC_W:0] w_len;
  logic          w_trigger;

  assign w_len     = {1'b0, brn_pc_in} - {1'b0, brn_tgt_in} + (PC_W+1)'(1);
  assign w_trigger = inst_valid_in & bck_lp_in & pred_result_in & ~mispred_in
                   & (brn_tgt_in <= brn_pc_in)
                   & (w_len <= (PC_W+1)'(MAX_BODY));

  always_comb begin
    w_state_nxt    = r_state;
    w_start_nxt    = r_start;
    w_end_nxt      = r_end;
    w_pc_nxt       = r_pc;
    w_iter_nxt     = r_iter;
    w_fetch_pc_nxt = r_fetch_pc;
    w_fetch_v_nxt  = 1'b0;
    w_active_nxt   = (r_state != IDLE);
    w_iter_out_nxt = r_iter_out;
    w_fnsh_nxt     = 1'b0;
    w_redir_v_nxt  = 1'b0;
    w_redir_pc_nxt = r_redir_pc;

    unique case (r_state)
      IDLE: begin
        w_fetch_pc_nxt = '0;
        w_iter_out_nxt = '0;
        w_redir_pc_nxt = '0;
        if (w_trigger) begin
          w_state_nxt = REPLAY;
          w_start_nxt = brn_tgt_in;
          w_end_nxt   = brn_pc_in;
          w_pc_nxt    = brn_tgt_in;
          w_iter_nxt  = ITER_W'(1);
        end
      end
      REPLAY: begin
        if (!stall_in) begin
          w_fetch_pc_nxt = r_pc;
          w_fetch_v_nxt  = 1'b1;
          w_iter_out_nxt = r_iter;
          if (r_pc == r_end) begin
            if (r_iter == LAST_ITER) begin
              w_state_nxt = FINISH;
            end else begin
              w_pc_nxt   = r_start;
              w_iter_nxt = r_iter + ITER_W'(1);
            end
          end else begin
            w_pc_nxt = r_pc + PC_W'(1);
          end
        end
      end
      FINISH: begin
        w_fnsh_nxt     = 1'b1;
        w_redir_v_nxt  = 1'b1;
        w_redir_pc_nxt = r_end + PC_W'(1);
        w_state_nxt    = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Flush overrides everything, including a same-cycle trigger or finish
    if (mispred_in) begin
      w_state_nxt    = IDLE;
      w_fetch_pc_nxt = '0;
      w_fetch_v_nxt  = 1'b0;
      w_active_nxt   = 1'b0;
      w_iter_out_nxt = '0;
      w_fnsh_nxt     = 1'b0;
      w_redir_v_nxt  = 1'b0;
      w_redir_pc_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_start    <= '0;
      r_end      <= '0;
      r_pc       <= '0;
      r_iter     <= '0;
      r_fetch_pc <= '0;
      r_fetch_v  <= 1'b0;
      r_active   <= 1'b0;
      r_iter_out <= '0;
      r_fnsh     <= 1'b0;
      r_redir_v  <= 1'b0;
      r_redir_pc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_start    <= w_start_nxt;
      r_end      <= w_end_nxt;
      r_pc       <= w_pc_nxt;
      r_iter     <= w_iter_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_fetch_v  <= w_fetch_v_nxt;
      r_active   <= w_active_nxt;
      r_iter_out <= w_iter_out_nxt;
      r_fnsh     <= w_fnsh_nxt;
      r_redir_v  <= w_redir_v_nxt;
      r_redir_pc <= w_redir_pc_nxt;
    end
  end

  assign fetch_pc_out     = r_fetch_pc;
  assign fetch_v_out      = r_fetch_v;
  assign unrll_active_out = r_active;
  assign iter_out         = r_iter_out;
  assign fnsh_unrll_out   = r_fnsh;
  assign redirect_v_out   = r_redir_v;
  assign redirect_pc_out  = r_redir_pc;

endmodule

// File: tb/tb_loop_unroll_ctrl.sv
// Directed bench for loop_unroll_ctrl: one instance with UNROLL_CNT=4 and one
// with UNROLL_CNT=2, both MAX_BODY=8, sharing all inputs.
module tb_loop_unroll_ctrl;

  logic        clk;
  logic        rst_n;
  logic        inst_valid_in, bck_lp_in, pred_result_in, stall_in, mispred_in;
  logic [15:0] brn_pc_in, brn_tgt_in;

  logic [15:0] fetch_pc_out, redirect_pc_out;
  logic        fetch_v_out, unrll_active_out, fnsh_unrll_out, redirect_v_out;
  logic [3:0]  iter_out;

  logic [15:0] fetch_pc2, redirect_pc2;
  logic        fetch_v2, active2, fnsh2, redirect_v2;
  logic [3:0]  iter2;

  int n_checks = 0;
  int n_err    = 0;

  loop_unroll_ctrl #(.UNROLL_CNT(4), .MAX_BODY(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_valid_in(inst_valid_in), .bck_lp_in(bck_lp_in),
    .pred_result_in(pred_result_in),
    .brn_pc_in(brn_pc_in), .brn_tgt_in(brn_tgt_in),
    .stall_in(stall_in), .mispred_in(mispred_in),
    .fetch_pc_out(fetch_pc_out), .fetch_v_out(fetch_v_out),
    .unrll_active_out(unrll_active_out), .iter_out(iter_out),
    .fnsh_unrll_out(fnsh_unrll_out), .redirect_v_out(redirect_v_out),
    .redirect_pc_out(redirect_pc_out)
  );

  loop_unroll_ctrl #(.UNROLL_CNT(2), .MAX_BODY(8)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .inst_valid_in(inst_valid_in), .bck_lp_in(bck_lp_in),
    .pred_result_in(pred_result_in),
    .brn_pc_in(brn_pc_in), .brn_tgt_in(brn_tgt_in),
    .stall_in(stall_in), .mispred_in(mispred_in),
    .fetch_pc_out(fetch_pc2), .fetch_v_out(fetch_v2),
    .unrll_active_out(active2), .iter_out(iter2),
    .fnsh_unrll_out(fnsh2), .redirect_v_out(redirect_v2),
    .redirect_pc_out(redirect_pc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_valid_in  = 1'b0;
    bck_lp_in      = 1'b0;
    pred_result_in = 1'b0;
    stall_in       = 1'b0;
    mispred_in     = 1'b0;
    brn_pc_in      = '0;
    brn_tgt_in     = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Present a trigger for exactly one edge
  task automatic trig(input logic [15:0] tgt, input logic [15:0] brn, input logic pred);
    inst_valid_in  = 1'b1;
    bck_lp_in      = 1'b1;
    pred_result_in = pred;
    brn_tgt_in     = tgt;
    brn_pc_in      = brn;
    step();
    inst_valid_in  = 1'b0;
    bck_lp_in      = 1'b0;
    pred_result_in = 1'b0;
  endtask

  task automatic chk_fetch(input string tag, input logic [15:0] pc, input logic [3:0] it);
    chk({tag, "_v"}, 32'(fetch_v_out), 32'd1);
    chk({tag, "_pc"}, 32'(fetch_pc_out), 32'(pc));
    chk({tag, "_iter"}, 32'(iter_out), 32'(it));
    chk({tag, "_act"}, 32'(unrll_active_out), 32'd1);
  endtask

  task automatic chk_finish(input string tag, input logic [15:0] rpc);
    chk({tag, "_fnsh"}, 32'(fnsh_unrll_out), 32'd1);
    chk({tag, "_rv"}, 32'(redirect_v_out), 32'd1);
    chk({tag, "_rpc"}, 32'(redirect_pc_out), 32'(rpc));
    chk({tag, "_fv"}, 32'(fetch_v_out), 32'd0);
    step();
    chk({tag, "_fnsh_off"}, 32'(fnsh_unrll_out), 32'd0);
    chk({tag, "_rv_off"}, 32'(redirect_v_out), 32'd0);
    chk({tag, "_act_off"}, 32'(unrll_active_out), 32'd0);
  endtask

  // Run n cycles and report whether any fetch or finish strobe appeared
  task automatic quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      seen = seen | fetch_v_out | fnsh_unrll_out;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [15:0] seq [8];
    do_reset();

    // Reset values
    chk("rst_fv",   32'(fetch_v_out), 32'd0);
    chk("rst_pc",   32'(fetch_pc_out), 32'd0);
    chk("rst_iter", 32'(iter_out), 32'd0);
    chk("rst_act",  32'(unrll_active_out), 32'd0);
    chk("rst_fnsh", 32'(fnsh_unrll_out), 32'd0);
    chk("rst_rv",   32'(redirect_v_out), 32'd0);
    chk("rst_rpc",  32'(redirect_pc_out), 32'd0);

    // Basic unroll: body 0x10..0x12, 3 replay copies
    trig(16'h0010, 16'h0012, 1'b1);
    chk("basic_lat_fv", 32'(fetch_v_out), 32'd0);
    for (int k = 0; k < 9; k++) begin
      step();
      chk_fetch("basic", 16'(16'h0010 + k % 3), 4'(1 + k / 3));
    end
    step();
    chk_finish("basic", 16'h0013);

    // Ineligible loops
    trig(16'h0010, 16'h0018, 1'b1);
    quiet("inelig_len9", 12);
    trig(16'h0010, 16'h0012, 1'b0);
    quiet("inelig_nopred", 12);
    trig(16'h0020, 16'h0010, 1'b1);
    quiet("inelig_rev", 12);

    // Stall for two cycles while the pending replay PC is 0x0011
    trig(16'h0010, 16'h0012, 1'b1);
    step();
    chk_fetch("stall_pre", 16'h0010, 4'd1);
    stall_in = 1'b1;
    step();
    chk("stall1_fv", 32'(fetch_v_out), 32'd0);
    chk("stall1_pc", 32'(fetch_pc_out), 32'h0010);
    step();
    chk("stall2_fv", 32'(fetch_v_out), 32'd0);
    chk("stall2_pc", 32'(fetch_pc_out), 32'h0010);
    stall_in = 1'b0;
    seq = '{16'h11, 16'h12, 16'h10, 16'h11, 16'h12, 16'h10, 16'h11, 16'h12};
    for (int k = 0; k < 8; k++) begin
      step();
      chk_fetch("stall_post", seq[k], 4'((k + 1) / 3 + 1));
    end
    step();
    chk_finish("stall", 16'h0013);

    // Mispredict during the 4th replay cycle
    trig(16'h0010, 16'h0012, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_fetch("mp", 16'(16'h0010 + k % 3), 4'(1 + k / 3));
    end
    mispred_in = 1'b1;
    step();
    mispred_in = 1'b0;
    chk("mp_fv",   32'(fetch_v_out), 32'd0);
    chk("mp_pc",   32'(fetch_pc_out), 32'd0);
    chk("mp_iter", 32'(iter_out), 32'd0);
    chk("mp_act",  32'(unrll_active_out), 32'd0);
    chk("mp_fnsh", 32'(fnsh_unrll_out), 32'd0);
    chk("mp_rv",   32'(redirect_v_out), 32'd0);
    quiet("mp_after", 12);

    // Trigger together with mispredict is ignored
    mispred_in = 1'b1;
    trig(16'h0010, 16'h0012, 1'b1);
    mispred_in = 1'b0;
    quiet("mp_trig", 12);

    // Wrap: redirect past 0xFFFF lands on 0x0000
    trig(16'hFFFE, 16'hFFFF, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk_fetch("wrap", 16'(16'hFFFE + k % 2), 4'(1 + k / 2));
    end
    step();
    chk_finish("wrap", 16'h0000);

    // Asynchronous reset mid-replay
    trig(16'h0010, 16'h0012, 1'b1);
    step();
    step();
    chk_fetch("arst_pre", 16'h0011, 4'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_fv",   32'(fetch_v_out), 32'd0);
    chk("arst_pc",   32'(fetch_pc_out), 32'd0);
    chk("arst_iter", 32'(iter_out), 32'd0);
    chk("arst_act",  32'(unrll_active_out), 32'd0);
    #2;
    rst_n = 1'b1;
    quiet("arst_idle", 6);

    // Single-instruction body on the UNROLL_CNT=2 instance
    do_reset();
    trig(16'h0040, 16'h0040, 1'b1);
    step();
    chk("one_fv",   32'(fetch_v2), 32'd1);
    chk("one_pc",   32'(fetch_pc2), 32'h0040);
    chk("one_iter", 32'(iter2), 32'd1);
    step();
    chk("one_fv_end", 32'(fetch_v2), 32'd0);
    chk("one_fnsh",   32'(fnsh2), 32'd1);
    chk("one_rv",     32'(redirect_v2), 32'd1);
    chk("one_rpc",    32'(redirect_pc2), 32'h0041);
    step();
    chk("one_fnsh_off", 32'(fnsh2), 32'd0);
    chk("one_act_off",  32'(active2), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
